// File: rtl/issue_alloc_if.sv
// Issue allocator handshake bundle between decode and the allocator.
// Carries issue request, commit/flush/release feedback and grant outputs.
interface issue_alloc_if #(
   parameter int ROB_DEPTH = 8,
   parameter int N_LS      = 6,
   parameter int N_ADD     = 3,
   parameter int N_MUL     = 2
);
   localparam int ROB_W    = $clog2(ROB_DEPTH);
   localparam int RS_TOTAL = N_LS + N_ADD + N_MUL;
   localparam int RS_W     = $clog2(RS_TOTAL + 2);

   logic                start;
   logic                issue_valid;
   logic [2:0]          operation;
   logic                commit_valid;
   logic                flush;
   logic [RS_TOTAL-1:0] rs_release;
   logic                issue_fire;
   logic [ROB_W-1:0]    rob_idx;
   logic [RS_W-1:0]     rs_idx;
   logic                struct_haz;
   logic [ROB_W:0]      rob_count;
   logic [ROB_W-1:0]    rob_head;
   logic [15:0]         stall_cnt;

   modport master (
      output start, issue_valid, operation, commit_valid, flush, rs_release,
      input  issue_fire, rob_idx, rs_idx, struct_haz, rob_count, rob_head,
             stall_cnt
   );

   modport slave (
      input  start, issue_valid, operation, commit_valid, flush, rs_release,
      output issue_fire, rob_idx, rs_idx, struct_haz, rob_count, rob_head,
             stall_cnt
   );
endinterface

// File: rtl/issue_alloc_unit.sv
// Tomasulo issue allocator: ROB tail/head/count and per-class station busy.
// Optional macro ALLOC_COMMIT_BYPASS_EN lets a same-cycle commit free a full ROB.
module issue_alloc_unit #(
   parameter int ROB_DEPTH = 8,
   parameter int N_LS      = 6,
   parameter int N_ADD     = 3,
   parameter int N_MUL     = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   issue_alloc_if.slave  bus
);
   localparam int ROB_W    = $clog2(ROB_DEPTH);
   localparam int RS_TOTAL = N_LS + N_ADD + N_MUL;
   localparam int RS_W     = $clog2(RS_TOTAL + 2);
   localparam int GARBAGE  = RS_TOTAL + 1;

   localparam logic [ROB_W:0]  FULL   = (ROB_W+1)'(ROB_DEPTH);
   localparam logic [RS_W-1:0] GARB_V = RS_W'(GARBAGE);

   logic [ROB_W-1:0]    head_q, tail_q;
   logic [ROB_W:0]      count_q;
   logic [RS_TOTAL-1:0] busy_q;
   logic [15:0]         stall_q;

   logic                is_ls, is_add, is_mul, is_nop;
   logic                req, found, rob_full, do_commit, fire;
   logic [RS_W-1:0]     sel;
   logic [RS_TOTAL-1:0] set_vec;

   // operation class decode
   always_comb begin
      is_add = 1'b0;
      is_mul = 1'b0;
      is_ls  = 1'b0;
      is_nop = 1'b0;
      unique case (1'b1)
         (bus.operation == 3'd0 || bus.operation == 3'd1): is_add = 1'b1;
         (bus.operation == 3'd2 || bus.operation == 3'd3): is_mul = 1'b1;
         (bus.operation == 3'd4 || bus.operation == 3'd5): is_ls  = 1'b1;
         default:                                          is_nop = 1'b1;
      endcase
   end

   // lowest free station of the requested class, from registered busy bits
   always_comb begin
      found = 1'b0;
      sel   = GARB_V;
      for (int i = 1; i <= RS_TOTAL; i++) begin
         if (!found && !busy_q[i-1] &&
             ((is_ls  && i <= N_LS) ||
              (is_add && i >  N_LS && i <= N_LS + N_ADD) ||
              (is_mul && i >  N_LS + N_ADD))) begin
            found = 1'b1;
            sel   = RS_W'(i);
         end
      end
   end

   // hazard, grant and fire; ROB-full may be waived by a same-cycle commit
   always_comb begin
      req       = bus.start & bus.issue_valid & ~is_nop;
      do_commit = bus.commit_valid & (count_q != '0);
`ifdef ALLOC_COMMIT_BYPASS_EN
      rob_full  = (count_q == FULL) & ~do_commit;
`else
      rob_full  = (count_q == FULL);
`endif
      bus.struct_haz = req & (rob_full | ~found);
      fire           = req & ~bus.struct_haz & ~bus.flush;
      bus.issue_fire = fire;
      bus.rs_idx     = (req & ~bus.struct_haz) ? sel : GARB_V;
      bus.rob_idx    = bus.start ? tail_q : '0;
      set_vec        = '0;
      for (int i = 1; i <= RS_TOTAL; i++) begin
         if (fire && sel == RS_W'(i)) set_vec[i-1] = 1'b1;
      end
   end

   assign bus.rob_count = count_q;
   assign bus.rob_head  = head_q;
   assign bus.stall_cnt = stall_q;

   // ROB pointers and station busy state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         busy_q  <= '0;
      end else if (!bus.start || bus.flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         busy_q  <= '0;
      end else begin
         busy_q <= (busy_q & ~bus.rs_release) | set_vec;
         if (fire) tail_q <= tail_q + 1'b1;
         if (do_commit) head_q <= head_q + 1'b1;
         if (fire && !do_commit) count_q <= count_q + 1'b1;
         else if (!fire && do_commit) count_q <= count_q - 1'b1;
      end
   end

   // saturating stall counter; unaffected by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (!bus.start) begin
         stall_q <= '0;
      end else if (bus.struct_haz && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end
endmodule
